// File: rtl/rf_write_ctrl.sv
// Register-file write arbiter: pipeline writebacks win, multi-cycle results wait in a FIFO.
// Optional starvation guard enabled by defining RF_WR_STARVE_GUARD_EN.
module rf_write_ctrl #(
  parameter int RF_ADDR_WIDTH = 5,
  parameter int RF_DATA_WIDTH = 32,
  parameter int BUF_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          n_reset,
  input  logic                          pipe_wr_en,
  input  logic [RF_ADDR_WIDTH-1:0]      pipe_w_addr,
  input  logic [RF_DATA_WIDTH-1:0]      pipe_w_data,
  input  logic                          mc_valid,
  input  logic [RF_ADDR_WIDTH-1:0]      mc_addr,
  input  logic [RF_DATA_WIDTH-1:0]      mc_data,
  output logic                          mc_ready,
  output logic                          rf_wr_en,
  output logic [RF_ADDR_WIDTH-1:0]      rf_w_addr,
  output logic [RF_DATA_WIDTH-1:0]      rf_w_data,
  input  logic [RF_ADDR_WIDTH-1:0]      q_addr_1,
  input  logic [RF_ADDR_WIDTH-1:0]      q_addr_2,
  output logic                          q_hit_1,
  output logic                          q_hit_2,
  output logic [$clog2(BUF_DEPTH):0]    buf_count,
  output logic                          wb_stall
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_FORCE} state_e;

  state_e                      state_q, state_d;
  logic [BUF_DEPTH-1:0]        valid_q, valid_d;
  logic [RF_ADDR_WIDTH-1:0]    addr_mem [BUF_DEPTH];
  logic [RF_DATA_WIDTH-1:0]    data_mem [BUF_DEPTH];
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]            occ_q, occ_d;
  logic                        rf_wr_en_q, rf_wr_en_d;
  logic [RF_ADDR_WIDTH-1:0]    rf_w_addr_q, rf_w_addr_d;
  logic [RF_DATA_WIDTH-1:0]    rf_w_data_q, rf_w_data_d;

  logic                        pipe_sel, push, pop, head_found;
  logic [PTR_W-1:0]            head_off, head_idx, scan_idx;
  logic [CNT_W-1:0]            freed, count_c;
  logic [BUF_DEPTH-1:0]        inv_match, q1_match, q2_match;

  assign pipe_sel = pipe_wr_en && (pipe_w_addr != '0);
  assign mc_ready = (occ_q != CNT_W'(BUF_DEPTH));
  assign push     = mc_valid && mc_ready && (mc_addr != '0) &&
                    !(pipe_wr_en && (mc_addr == pipe_w_addr));

  generate
    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
      assign inv_match[gi] = pipe_sel && (addr_mem[gi] == pipe_w_addr);
      assign q1_match[gi]  = valid_q[gi] && (addr_mem[gi] == q_addr_1);
      assign q2_match[gi]  = valid_q[gi] && (addr_mem[gi] == q_addr_2);
    end
  endgenerate

  assign q_hit_1 = (|q1_match) && (q_addr_1 != '0);
  assign q_hit_2 = (|q2_match) && (q_addr_2 != '0);

  // Oldest still-valid occupied slot; invalidated slots ahead of it are freed for nothing.
  always_comb begin
    head_found = 1'b0;
    head_off   = '0;
    scan_idx   = '0;
    for (int k = BUF_DEPTH - 1; k >= 0; k--) begin
      scan_idx = rd_ptr_q + PTR_W'(k);
      if ((CNT_W'(k) < occ_q) && valid_q[scan_idx]) begin
        head_found = 1'b1;
        head_off   = PTR_W'(k);
      end
    end
  end

  assign head_idx = rd_ptr_q + head_off;
  assign pop      = head_found && !pipe_sel;

  always_comb begin
    count_c = '0;
    for (int k = 0; k < BUF_DEPTH; k++) begin
      count_c = count_c + CNT_W'(valid_q[k]);
    end
  end

  assign buf_count = count_c;

  always_comb begin
    valid_d = valid_q & ~inv_match;
    if (pop) valid_d[head_idx] = 1'b0;
    if (push) valid_d[wr_ptr_q] = 1'b1;

    if (pop) begin
      freed    = {1'b0, head_off} + CNT_W'(1);
      rd_ptr_d = head_idx + PTR_W'(1);
    end else if (head_found) begin
      freed    = {1'b0, head_off};
      rd_ptr_d = head_idx;
    end else begin
      freed    = occ_q;
      rd_ptr_d = wr_ptr_q;
    end
    occ_d    = occ_q - freed + CNT_W'(push);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);

    rf_wr_en_d  = pipe_sel || pop;
    rf_w_addr_d = rf_w_addr_q;
    rf_w_data_d = rf_w_data_q;
    if (pipe_sel) begin
      rf_w_addr_d = pipe_w_addr;
      rf_w_data_d = pipe_w_data;
    end else if (pop) begin
      rf_w_addr_d = addr_mem[head_idx];
      rf_w_data_d = data_mem[head_idx];
    end
  end

`ifdef RF_WR_STARVE_GUARD_EN
  logic [2:0] starve_q, starve_d;
  logic       blocked;

  assign blocked  = (state_q == ST_PEND) && head_found && pipe_sel;
  assign wb_stall = (state_q == ST_FORCE);

  // Seven blocked cycles in a row make the following cycle the forced-drain cycle.
  always_comb begin
    state_d  = (|valid_d) ? ST_PEND : ST_IDLE;
    starve_d = '0;
    if (state_q != ST_FORCE && blocked) begin
      starve_d = starve_q + 3'd1;
      if (starve_q == 3'd6 && (|valid_d)) begin
        state_d  = ST_FORCE;
        starve_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) starve_q <= '0;
    else          starve_q <= starve_d;
  end
`else
  assign wb_stall = 1'b0;

  always_comb begin
    state_d = (|valid_d) ? ST_PEND : ST_IDLE;
  end
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= ST_IDLE;
      valid_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      occ_q       <= '0;
      rf_wr_en_q  <= 1'b0;
      rf_w_addr_q <= '0;
      rf_w_data_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
      rf_wr_en_q  <= rf_wr_en_d;
      rf_w_addr_q <= rf_w_addr_d;
      rf_w_data_q <= rf_w_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= mc_addr;
      data_mem[wr_ptr_q] <= mc_data;
    end
  end

  assign rf_wr_en  = rf_wr_en_q;
  assign rf_w_addr = rf_w_addr_q;
  assign rf_w_data = rf_w_data_q;

endmodule

// File: doc/rf_write_ctrl.md
RF_WRITE_CTRL -- requirements
Module: rf_write_ctrl

Interface
REQ-001 Parameter RF_ADDR_WIDTH, default 5, register address bits.
REQ-002 Parameter RF_DATA_WIDTH, default 32, bits per register word.
REQ-003 Parameter BUF_DEPTH, default 4, multi-cycle result buffer entries; a power of 2, at least 2.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, named as follows.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 n_reset  in  1  asynchronous active-low reset.
REQ-007 pipe_wr_en  in  1  main-pipeline writeback request; cannot be back-pressured.
REQ-008 pipe_w_addr  in  RF_ADDR_WIDTH  pipeline destination register.
REQ-009 pipe_w_data  in  RF_DATA_WIDTH  pipeline result.
REQ-010 mc_valid  in  1  multi-cycle unit result valid.
REQ-011 mc_addr  in  RF_ADDR_WIDTH  multi-cycle destination register.
REQ-012 mc_data  in  RF_DATA_WIDTH  multi-cycle result.
REQ-013 mc_ready  out  1  buffer can accept; equals (buffer not full).
REQ-014 rf_wr_en  out  1  register-file write enable, registered.
REQ-015 rf_w_addr  out  RF_ADDR_WIDTH  register-file write address, registered.
REQ-016 rf_w_data  out  RF_DATA_WIDTH  register-file write data, registered.
REQ-017 q_addr_1, q_addr_2  in  RF_ADDR_WIDTH  hazard-unit query addresses.
REQ-018 q_hit_1, q_hit_2  out  1  a valid buffered write targets the query address; combinational.
REQ-019 buf_count  out  clog2(BUF_DEPTH)+1  valid entries held.
REQ-020 wb_stall  out  1  pipeline-stall request from the starvation guard.

Function
REQ-021 The block SHALL issue register-file writes one cycle after the selecting cycle.
- Output latency: 1 cycle.
- Selection order per cycle: (a) pipe_wr_en with pipe_w_addr != 0; else (b) buffer head, popped; else rf_wr_en=0.
REQ-022 A transfer SHALL occur when mc_valid && mc_ready, and SHALL not depend on same-cycle pops.
REQ-023 A transferred mc result SHALL be dropped (handshake completes, nothing stored) in either case:
- mc_addr == 0;
- mc_addr equals pipe_w_addr while pipe_wr_en=1 in the same cycle (the pipeline write is architecturally younger).
REQ-024 When pipe_wr_en=1 and pipe_w_addr != 0, every buffered entry with that address SHALL be invalidated that cycle.
- Invalidated entries are skipped on pop without using a write slot.
- They stop counting in buf_count and in q_hit the next cycle.
REQ-025 Pipeline writes to register 0 SHALL produce rf_wr_en=0 and free the slot for the buffer head.
REQ-026 The buffer SHALL be FIFO-ordered, with wrap-around of read/write pointers modulo BUF_DEPTH.
REQ-027 q_hit_n SHALL be 1 iff some valid entry's address equals q_addr_n and q_addr_n != 0.
REQ-028 State machine:
- IDLE: buffer empty.
- PEND: buffer non-empty.
- FORCE: see REQ-033.
- Transitions IDLE->PEND on store; PEND->IDLE when the last valid entry pops or is invalidated.
REQ-029 A simultaneous push and pop SHALL leave buf_count unchanged.

Reset
REQ-030 While n_reset=0, the block SHALL clear all entry valid bits and pointers, set the state to IDLE, and drive rf_wr_en=0, rf_w_addr=0, rf_w_data=0, buf_count=0 and wb_stall=0.
- mc_ready=1 and q_hit_n=0 follow from the empty buffer.
REQ-031 Reset asserted mid-operation SHALL discard all buffered entries; discarded writes SHALL never reach the register file.

Configuration
REQ-032 Macro RF_WR_STARVE_GUARD_EN SHALL select the starvation guard.
REQ-033 With RF_WR_STARVE_GUARD_EN defined, the block SHALL count consecutive PEND cycles in which the head is blocked by a pipeline write; on the 8th such cycle it enters FORCE.
- FORCE asserts wb_stall for exactly one cycle.
- The upstream pipeline holds pipe_wr_en=0 during that cycle, and the head pops.
- Afterwards: return to PEND or IDLE, counter cleared.
REQ-034 Without RF_WR_STARVE_GUARD_EN, the block SHALL tie wb_stall to 0, never enter FORCE, and omit the counter.

Verification
REQ-035 Pipe write x5=0x11 with an empty buffer -> next cycle rf_wr_en=1, rf_w_addr=5, rf_w_data=0x11.
REQ-036 mc write x7=0xAA with pipe idle -> stored (buf_count=1, q_hit for 7 = 1) -> popped the next cycle -> rf write x7=0xAA one cycle later -> buf_count=0.
REQ-037 Fill 4 mc entries under continuous pipe writes -> mc_ready=0; an extra mc_valid is held off; a pipe-idle cycle pops one entry -> mc_ready=1 the next cycle.
REQ-038 Buffered x9=0x1 followed by a pipe write x9=0x2 -> entry invalidated; only x9=0x2 is written; q_hit for 9 = 0 afterwards.
REQ-039 mc write to x0, and pipe write to x0 -> no rf_wr_en in either case; buf_count unchanged.
REQ-040 With RF_WR_STARVE_GUARD_EN: one buffered entry plus 8 cycles of pipe writes -> wb_stall=1 on the 8th, head written the next cycle. Without the macro, wb_stall stays 0 throughout.
